// File: rtl/mac_pipe_pkg.sv
// Shared types and helpers for the pipelined signed multiply-accumulate unit.
// Beat flags travel with each product; saturation limits are derived from a width.
package mac_pipe_pkg;

    localparam int MAXW = 64;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_t;

    function automatic logic add_ovf(input logic a_s, input logic b_s,
                                     input logic s_s);
        return (a_s == b_s) && (s_s != a_s);
    endfunction

    function automatic logic [MAXW-1:0] sat_hi(input int w);
        return (MAXW'(1) << (w - 1)) - MAXW'(1);
    endfunction

    function automatic logic [MAXW-1:0] sat_lo(input int w);
        return ~sat_hi(w);
    endfunction

endpackage

// File: rtl/mac_pipe_mul.sv
// Signed multiplier with PIPE enabled register stages.
// Beat flags ride alongside the product.
module mac_pipe_mul
    import mac_pipe_pkg::*;
#(
    parameter int OPWIDTH  = 8,
    parameter int ACCWIDTH = 32,
    parameter int PIPE     = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [OPWIDTH-1:0]  a_i,
    input  logic [OPWIDTH-1:0]  b_i,
    input  beat_t               flags_i,
    output logic [ACCWIDTH-1:0] prod_o,
    output beat_t               flags_o
);

    localparam int PW = 2 * OPWIDTH;

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] p_full;
    logic [ACCWIDTH-1:0]  p_ext;

    logic [ACCWIDTH-1:0] prod_q [PIPE];
    beat_t               flg_q  [PIPE];

    assign a_x    = PW'($signed(a_i));
    assign b_x    = PW'($signed(b_i));
    assign p_full = a_x * b_x;
    assign p_ext  = ACCWIDTH'(p_full);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < PIPE; i++) begin
                prod_q[i] <= '0;
                flg_q[i]  <= '0;
            end
        end else if (en_i) begin
            prod_q[0] <= p_ext;
            flg_q[0]  <= flags_i;
            for (int i = 1; i < PIPE; i++) begin
                prod_q[i] <= prod_q[i-1];
                flg_q[i]  <= flg_q[i-1];
            end
        end
    end

    assign prod_o  = prod_q[PIPE-1];
    assign flags_o = flg_q[PIPE-1];

endmodule

// File: rtl/mac_pipe.sv
// Pipelined signed MAC: one result per first..last frame, valid/ready both sides.
// Define MAC_PIPE_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter int OPWIDTH  = 8,
    parameter int ACCWIDTH = 32,
    parameter int PIPE     = 2,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [OPWIDTH-1:0]  D0_i,
    input  logic [OPWIDTH-1:0]  D1_i,
    input  logic                first_i,
    input  logic                last_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [ACCWIDTH-1:0] Q_o,
    output logic [CNTWIDTH-1:0] cnt_o,
    output logic                ovf_o,
    output logic                valid_o,
    input  logic                ready_i
);

    localparam int MSB = ACCWIDTH - 1;

`ifdef MAC_PIPE_SAT_EN
    localparam logic [MAXW-1:0]     HI_W   = sat_hi(ACCWIDTH);
    localparam logic [MAXW-1:0]     LO_W   = sat_lo(ACCWIDTH);
    localparam logic [ACCWIDTH-1:0] SAT_HI = HI_W[ACCWIDTH-1:0];
    localparam logic [ACCWIDTH-1:0] SAT_LO = LO_W[ACCWIDTH-1:0];
`endif

    logic                adv;
    beat_t               in_flg;
    beat_t               tail;
    logic [ACCWIDTH-1:0] prod;
    logic [ACCWIDTH-1:0] base;
    logic [ACCWIDTH-1:0] sum;
    logic                ovf;

    logic [ACCWIDTH-1:0] acc_q, acc_d, q_q, q_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d, cnto_q, cnto_d;
    logic                ovfs_q, ovfs_d, ovfo_q, ovfo_d;
    logic                vld_q, vld_d;

    assign adv     = ~(vld_q & ~ready_i);
    assign ready_o = adv;
    assign in_flg  = '{valid: valid_i, first: first_i, last: last_i};

    mac_pipe_mul #(
        .OPWIDTH (OPWIDTH),
        .ACCWIDTH(ACCWIDTH),
        .PIPE    (PIPE)
    ) u_mul (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .en_i   (adv),
        .a_i    (D0_i),
        .b_i    (D1_i),
        .flags_i(in_flg),
        .prod_o (prod),
        .flags_o(tail)
    );

    always_comb begin
        base   = tail.first ? '0 : acc_q;
        sum    = base + prod;
        // With first=1 the base is zero, so no overflow can be flagged.
        ovf    = add_ovf(base[MSB], prod[MSB], sum[MSB]);
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ovfs_d = ovfs_q;
        q_d    = q_q;
        cnto_d = cnto_q;
        ovfo_d = ovfo_q;
        vld_d  = vld_q;
        if (vld_q && ready_i) begin
            vld_d = 1'b0;
        end
        if (adv && tail.valid) begin
            acc_d = sum;
`ifdef MAC_PIPE_SAT_EN
            if (ovf) begin
                acc_d = base[MSB] ? SAT_LO : SAT_HI;
            end
`endif
            cnt_d  = tail.first ? CNTWIDTH'(1) : cnt_q + CNTWIDTH'(1);
            ovfs_d = (ovfs_q & ~tail.first) | ovf;
            if (tail.last) begin
                q_d    = acc_d;
                cnto_d = cnt_d;
                ovfo_d = ovfs_d;
                vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            ovfs_q <= 1'b0;
            q_q    <= '0;
            cnto_q <= '0;
            ovfo_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovfs_q <= ovfs_d;
            q_q    <= q_d;
            cnto_q <= cnto_d;
            ovfo_q <= ovfo_d;
            vld_q  <= vld_d;
        end
    end

    assign Q_o     = q_q;
    assign cnt_o   = cnto_q;
    assign ovf_o   = ovfo_q;
    assign valid_o = vld_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe at OPWIDTH=8, ACCWIDTH=18, PIPE=2.
// Honours MAC_PIPE_SAT_EN for the overflow expectation.
module tb_mac_pipe;

    localparam int OPW = 8;
    localparam int ACW = 18;
    localparam int PIP = 2;
    localparam int CNW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [OPW-1:0] d0, d1;
    logic           first, last, vin, rdy_o;
    logic [ACW-1:0] q;
    logic [CNW-1:0] cnt;
    logic           ovf, vout, rdy_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ACW-1:0] q;
        logic [CNW-1:0] c;
        logic           o;
    } res_t;

    res_t resq[$];

    always #5 clk = ~clk;

    mac_pipe #(
        .OPWIDTH (OPW),
        .ACCWIDTH(ACW),
        .PIPE    (PIP),
        .CNTWIDTH(CNW)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .D0_i   (d0),
        .D1_i   (d1),
        .first_i(first),
        .last_i (last),
        .valid_i(vin),
        .ready_o(rdy_o),
        .Q_o    (q),
        .cnt_o  (cnt),
        .ovf_o  (ovf),
        .valid_o(vout),
        .ready_i(rdy_i)
    );

    always @(posedge clk) begin
        if (rst_n && vout && rdy_i) begin
            resq.push_back('{q: q, c: cnt, o: ovf});
        end
    end

    function automatic logic [31:0] q18(input int v);
        logic [31:0] t;
        t = 32'(v);
        return {14'b0, t[17:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int a, input int b, input logic f,
                        input logic l);
        @(negedge clk);
        d0    = 8'(a);
        d1    = 8'(b);
        first = f;
        last  = l;
        vin   = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        vin   = 1'b0;
        first = 1'b0;
        last  = 1'b0;
    endtask

    task automatic get_res(input string tag, input int eq, input int ec,
                           input logic eo);
        res_t r;
        int   n;
        n = 0;
        while (resq.size() == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (resq.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            r = resq.pop_front();
            check({tag, "_q"}, {14'b0, r.q}, q18(eq));
            check({tag, "_cnt"}, {16'b0, r.c}, 32'(ec));
            check({tag, "_ovf"}, {31'b0, r.o}, {31'b0, eo});
        end
    endtask

    int exp_ovf_q;

    initial begin
        rst_n = 1'b0;
        d0 = '0; d1 = '0; first = 1'b0; last = 1'b0;
        vin = 1'b0; rdy_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_q", {14'b0, q}, 32'd0);
        check("rst_cnt", {16'b0, cnt}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_vld", {31'b0, vout}, 32'd0);
        check("rst_rdy", {31'b0, rdy_o}, 32'd1);
        rst_n = 1'b1;

        // No open frame: accumulates onto zero.
        send(3, 3, 1'b0, 1'b1);
        idle();
        get_res("noframe", 9, 1, 1'b0);

        // Single beat with exact latency.
        send(-3, 5, 1'b1, 1'b1);
        @(negedge clk);
        vin = 1'b0;
        check("lat_e0", {31'b0, vout}, 32'd0);
        @(negedge clk);
        check("lat_e1", {31'b0, vout}, 32'd0);
        @(negedge clk);
        check("lat_e2", {31'b0, vout}, 32'd1);
        get_res("single", -15, 1, 1'b0);

        send(1, 2, 1'b1, 1'b0);
        send(3, 4, 1'b0, 1'b0);
        send(-5, 6, 1'b0, 1'b0);
        send(7, -8, 1'b0, 1'b1);
        idle();
        get_res("frame4", -72, 4, 1'b0);

`ifdef MAC_PIPE_SAT_EN
        exp_ovf_q = 131071;
`else
        exp_ovf_q = -131072;
`endif
        for (int i = 0; i < 8; i++) begin
            send(-128, -128, i == 0, i == 7);
        end
        idle();
        get_res("ovf", exp_ovf_q, 8, 1'b1);

        // Mid-frame restart drops earlier beats.
        send(9, 9, 1'b1, 1'b0);
        send(2, 3, 1'b1, 1'b0);
        send(1, 1, 1'b0, 1'b1);
        idle();
        get_res("restart", 7, 2, 1'b0);

        rdy_i = 1'b0;
        send(2, 3, 1'b1, 1'b1);
        send(4, 5, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_vld", {31'b0, vout}, 32'd1);
            check("bp_q", {14'b0, q}, q18(6));
            check("bp_rdy", {31'b0, rdy_o}, 32'd0);
        end
        rdy_i = 1'b1;
        get_res("bp_a", 6, 1, 1'b0);
        get_res("bp_b", 20, 1, 1'b0);
        repeat (4) @(negedge clk);
        check("bp_nodup", 32'(resq.size()), 32'd0);
        check("bp_idle", {31'b0, vout}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            send(10, 10, i == 0, 1'b0);
        end
        @(negedge clk);
        vin   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_q", {14'b0, q}, 32'd0);
        check("mrst_cnt", {16'b0, cnt}, 32'd0);
        check("mrst_vld", {31'b0, vout}, 32'd0);
        rst_n = 1'b1;
        send(2, 2, 1'b1, 1'b1);
        idle();
        get_res("mrst", 4, 1, 1'b0);

        send(1, 1, 1'b1, 1'b0);
        idle();
        idle();
        send(2, 2, 1'b0, 1'b1);
        idle();
        get_res("bubble", 5, 2, 1'b0);

        repeat (3) @(negedge clk);
        check("tail_empty", 32'(resq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
